fp_mult_arbiter: RTL and testbench

- Shares one pipelined fp_mult instance between N_REQ independent requesters, for example the accelerator FSM, the CORDIC post-scaler and a Nios custom-instruction port.
- Arbitration is round-robin, with at most one issue per cycle.
- The block tracks each in-flight operation with a requester-ID shift pipeline of depth MUL_LAT, and routes each result back to its owner as a one-cycle response pulse.
- The block sits between the requesters and the multiplier; the multiplier is instantiated by the parent and connected through the mul_* ports.

---
 rtl/accel_pkg.sv | 26 ++
 rtl/fp_mult_arbiter_rr_arbiter.sv | 49 ++++
 rtl/fp_mult_arbiter.sv | 119 +++++++++++
 tb/tb_fp_mult_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : accel_pkg
//  Description : Shared constants and types for the accelerator datapath:
//                IEEE-754 single-precision constants, the fp_mult latency
//                default and the in-flight tag record used by resource
//                arbiters.
//  Revision    : 1.0 - initial release
// ============================================================================
package accel_pkg;

    localparam logic [31:0] FP_ONE          = 32'h3F80_0000;
    localparam logic [31:0] FP_HALF         = 32'h3F00_0000;
    localparam int          DEFAULT_MUL_LAT = 3;

    // Tag ID field is sized for the largest supported requester count (8),
    // so one tag type serves every arbiter instance.
    localparam int          TAG_ID_W        = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/fp_mult_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Searches i_req starting
//                at index i_ptr, wrapping modulo N; the first set bit wins.
//  Ports       : i_req   - request vector
//                i_ptr   - search start index (0..N-1)
//                o_grant - one-hot grant (all zero when no request)
//                o_idx   - encoded index of the winner
//                o_any   - at least one request granted
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    int            w_j;
    logic [IW-1:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        w_pos   = '0;
        for (int k = 0; k < N; k++) begin
            // ptr + k is below 2N, so a single subtraction wraps it
            w_j = int'(i_ptr) + k;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            w_pos = IW'(w_j);
            if (!o_any && i_req[w_pos]) begin
                o_any          = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mult_arbiter
//  Description : Shares one free-running, fixed-latency fp_mult between
//                N_REQ requesters. Round-robin issue of at most one operation
//                per cycle; a requester-ID pipe of depth MUL_LAT routes each
//                product back to its owner as a one-cycle strobe.
//  Ports       : clk, reset (sync, active-low), clk_en (gates issue only),
//                quiesce (blocks new grants), req_valid/req_a/req_b (packed
//                per requester), req_ready (one-hot grant), resp_valid
//                (one-hot result strobe), resp_data, mul_a/mul_b/mul_q (to
//                the shared multiplier), idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_mult_arbiter
    import accel_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = DEFAULT_MUL_LAT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    input  logic                quiesce,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*32-1:0] req_a,
    input  logic [N_REQ*32-1:0] req_b,
    output logic [N_REQ-1:0]    req_ready,
    output logic [N_REQ-1:0]    resp_valid,
    output logic [31:0]         resp_data,
    output logic [31:0]         mul_a,
    output logic [31:0]         mul_b,
    input  logic [31:0]         mul_q,
    output logic                idle
);

    localparam int ID_W = $clog2(N_REQ);

    logic [ID_W-1:0]  r_rr_ptr;
    tag_t             r_tag [MUL_LAT];

    logic             w_issue_en;
    logic [N_REQ-1:0] w_req_gated;
    logic [N_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_win_id;
    logic             w_grant_any;
    logic             w_any_inflight;
    tag_t             w_tag_in;
    tag_t             w_tail;

    // Reset is folded into the enable so no grant is shown while in reset.
    assign w_issue_en  = clk_en && !quiesce && reset;
    assign w_req_gated = req_valid & {N_REQ{w_issue_en}};

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .i_req   (w_req_gated),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_win_id),
        .o_any   (w_grant_any)
    );

    assign req_ready = w_grant;

    // The multiplier samples operands at the grant edge; idle cycles feed 0.
    assign mul_a = w_grant_any ? req_a[int'(w_win_id)*32 +: 32] : 32'h0;
    assign mul_b = w_grant_any ? req_b[int'(w_win_id)*32 +: 32] : 32'h0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rr_ptr <= '0;
        end else if (w_grant_any) begin
            r_rr_ptr <= (int'(w_win_id) == N_REQ - 1) ? '0 : w_win_id + 1'b1;
        end
    end

    assign w_tag_in.valid = w_grant_any;
    assign w_tag_in.id    = TAG_ID_W'(w_win_id);

    // The multiplier is free-running, so the tag pipe shifts every cycle
    // regardless of clk_en; in-flight results always drain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s < MUL_LAT; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_tag[0] <= w_tag_in;
            for (int s = 1; s < MUL_LAT; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    assign w_tail = r_tag[MUL_LAT-1];

    always_comb begin
        w_any_inflight = 1'b0;
        for (int s = 0; s < MUL_LAT; s++) begin
            w_any_inflight = w_any_inflight | r_tag[s].valid;
        end
    end

    // Strobe is suppressed while reset is held so a flushed operation never
    // reaches its requester.
    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            resp_valid[i] = w_tail.valid && reset && (w_tail.id == TAG_ID_W'(i));
        end
    end

    assign resp_data = mul_q;
    assign idle      = (!w_any_inflight || !reset) && !w_grant_any;

endmodule
`default_nettype wire

// File: tb/tb_fp_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_mult_arbiter
//  Description : Self-checking bench for fp_mult_arbiter. A behavioural
//                fixed-latency multiplier drives mul_q; a reference model
//                (round-robin search plus a queue of expected responses)
//                checks every cycle. Directed scenarios are followed by a
//                randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mult_arbiter;
    import accel_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 3;

    logic            clk       = 1'b0;
    logic            reset     = 1'b0;
    logic            clk_en    = 1'b1;
    logic            quiesce   = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*32-1:0] req_a     = '0;
    logic [N*32-1:0] req_b     = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic [31:0]     resp_data;
    logic [31:0]     mul_a;
    logic [31:0]     mul_b;
    logic [31:0]     mul_q;
    logic            idle;

    always #5 clk = ~clk;

    fp_mult_arbiter #(
        .N_REQ   (N),
        .MUL_LAT (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .quiesce    (quiesce),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_q      (mul_q),
        .idle       (idle)
    );

    // Single-precision multiply for normal operands, truncating rounding.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 10'd1;
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [7:0] e;
        e = 8'($urandom_range(144, 110));
        return {1'($urandom_range(1, 0)), e, 23'($urandom)};
    endfunction

    // Behavioural multiplier: operands sampled at an edge, product LAT edges later.
    logic [31:0] mq_pipe [LAT] = '{default: '0};
    always @(posedge clk) begin
        mq_pipe[0] <= fmul(mul_a, mul_b);
        for (int s = 1; s < LAT; s++) mq_pipe[s] <= mq_pipe[s-1];
    end
    assign mul_q = mq_pipe[LAT-1];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   m_ptr = 0;

    always @(negedge clk) begin : monitor
        logic [N-1:0] eg;
        logic [N-1:0] erv;
        logic [31:0]  erd;
        logic         eidle;
        logic         busy;
        int           ewin;
        int           j;
        eg   = '0;
        erv  = '0;
        erd  = '0;
        ewin = -1;
        if (reset && clk_en && !quiesce) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (ewin < 0 && req_valid[j]) ewin = j;
            end
        end
        if (ewin >= 0) eg[ewin] = 1'b1;
        busy = (sb.size() > 0);
        if (sb.size() > 0 && sb[0].due == cyc) begin
            if (reset) begin
                erv[sb[0].id] = 1'b1;
                erd           = sb[0].data;
            end
            void'(sb.pop_front());
        end
        eidle = (!reset || !busy) && (ewin < 0);

        chk("req_ready", 32'(req_ready), 32'(eg));
        chk("resp_valid", 32'(resp_valid), 32'(erv));
        if (erv != '0) chk("resp_data", resp_data, erd);
        chk("idle", 32'(idle), 32'(eidle));
        chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        chk("resp_onehot0", 32'($onehot0(resp_valid)), 32'd1);
        if (quiesce || !clk_en) chk("ready_gated", 32'(req_ready), 32'd0);

        if (!reset) begin
            m_ptr = 0;
            sb.delete();
        end else if (ewin >= 0) begin
            sb.push_back('{due: cyc + LAT, id: ewin,
                           data: fmul(req_a[ewin*32 +: 32], req_b[ewin*32 +: 32])});
            m_ptr = (ewin + 1) % N;
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    logic [N-1:0] acc;
    logic [N-1:0] keep = '0;

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_valid[i]      = 1'b1;
    endtask

    // Call right after a negedge: record acceptances, move to the next drive point.
    task automatic next_drive();
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (acc[i] && !keep[i]) req_valid[i] = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            next_drive();
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int found;
        int cnt;

        // Reset with all requesters asserting
        set_req(0, 32'h4000_0000, 32'h3F80_0000);
        set_req(1, 32'h3FC0_0000, 32'h3FC0_0000);
        set_req(2, 32'h4000_0000, 32'h4040_0000);
        set_req(3, 32'h3F00_0000, 32'h4080_0000);
        keep = '1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_resp", 32'(resp_valid), 32'd0);
            chk("rst_idle", 32'(idle), 32'd1);
            next_drive();
        end
        reset = 1'b1;

        // Round-robin contention: grants 0,1,2,3,0,... responses follow in order
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_order", 32'(req_ready), 32'd1 << (k % 4));
            if (k >= 3) chk("rr_resp_order", 32'(resp_valid), 32'd1 << ((k - 3) % 4));
            if (k == 4) chk("rr_req1_data", resp_data, 32'h4010_0000);
            next_drive();
        end
        keep      = '0;
        req_valid = '0;
        step(5);

        // Single request
        set_req(2, 32'h4000_0000, 32'h4040_0000);
        @(negedge clk);
        chk("single_grant", 32'(req_ready), 32'h4);
        next_drive();
        step(2);
        @(negedge clk);
        chk("single_resp_valid", 32'(resp_valid), 32'h4);
        chk("single_resp_data", resp_data, 32'h40C0_0000);
        next_drive();
        @(negedge clk);
        chk("single_idle_after", 32'(idle), 32'd1);
        next_drive();

        // clk_en gating after two back-to-back grants (pointer sits at 3)
        set_req(0, 32'h3F80_0000, 32'h4040_0000);
        set_req(1, 32'h3F00_0000, 32'h3F00_0000);
        @(negedge clk);
        chk("ce_grant0", 32'(req_ready), 32'h1);
        next_drive();
        @(negedge clk);
        chk("ce_grant1", 32'(req_ready), 32'h2);
        next_drive();
        clk_en = 1'b0;
        set_req(2, rnd_fp(), rnd_fp());
        set_req(3, rnd_fp(), rnd_fp());
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("ce_no_grant", 32'(req_ready), 32'd0);
            if (j == 1) chk("ce_resp0", 32'(resp_valid), 32'h1);
            if (j == 2) chk("ce_resp1", 32'(resp_valid), 32'h2);
            next_drive();
        end
        clk_en = 1'b1;
        @(negedge clk);
        chk("ce_resume", 32'(req_ready), 32'h4);
        next_drive();
        @(negedge clk);
        chk("ce_resume_next", 32'(req_ready), 32'h8);
        next_drive();
        step(6);

        // Quiesce with three operations in flight
        for (int i = 0; i < 3; i++) set_req(i, rnd_fp(), rnd_fp());
        step(3);
        quiesce = 1'b1;
        set_req(3, rnd_fp(), rnd_fp());
        found = -1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (idle && found < 0) found = j;
            next_drive();
        end
        chk("quiesce_idle_delay", 32'(found), 32'd3);
        quiesce = 1'b0;
        step(6);

        // Quiesce again, then reset one cycle later: flushed results never strobe
        for (int i = 0; i < 3; i++) set_req(i, rnd_fp(), rnd_fp());
        step(3);
        quiesce = 1'b1;
        step(1);
        reset = 1'b0;
        cnt = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (resp_valid != '0) cnt++;
            next_drive();
            reset = 1'b1;
        end
        chk("flush_no_resp", 32'(cnt), 32'd0);
        quiesce = 1'b0;
        step(2);

        // Randomized traffic
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    if ($urandom_range(1, 0) == 1) set_req(i, rnd_fp(), rnd_fp());
                    else req_valid[i] = 1'b0;
                end else if (!req_valid[i]) begin
                    if ($urandom_range(9, 0) < 4) set_req(i, rnd_fp(), rnd_fp());
                end else if ($urandom_range(19, 0) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            clk_en  = ($urandom_range(9, 0) != 0);
            quiesce = ($urandom_range(19, 0) == 0);
            reset   = ($urandom_range(99, 0) != 0);
        end
        clk_en    = 1'b1;
        quiesce   = 1'b0;
        reset     = 1'b1;
        req_valid = '0;
        step(6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
